hazard_stall_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Sits beside the ID stage and produces the PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush.
- Covers hazards that EX-stage forwarding cannot resolve:
  - load-use;
  - ID-resolved branch operand dependencies;
  - multi-cycle multiply occupancy.
- Also keeps a saturating stall-cycle statistics counter.

---
 rtl/hazard_stall_unit.sv | 123 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage hazard controller: load-use, branch-operand and multiply stalls.
module hazard_stall_unit #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_UsesRt,
    input  logic             Branch_ID,
    input  logic             BranchTaken_ID,
    input  logic [4:0]       ID_EX_DstReg,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_MulStart,
    input  logic [4:0]       EX_MEM_DstReg,
    input  logic             EX_MEM_MemRead,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCount
);

    localparam int MW = $clog2(MUL_LATENCY);
    localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_LATENCY - 2);

    typedef enum logic [1:0] {RUN, BR_LOAD_WAIT, MUL_WAIT} state_t;

    state_t        state, state_next;
    logic [MW-1:0] mul_cnt, mul_cnt_next;
    logic          match_e, match_m;
    logic          load_use, br_alu_dep, br_mem_dep;

    assign match_e = (ID_EX_DstReg != 5'd0) &&
                     ((ID_EX_DstReg == IF_ID_rs) || (IF_ID_UsesRt && (ID_EX_DstReg == IF_ID_rt)));
    assign match_m = (EX_MEM_DstReg != 5'd0) &&
                     ((EX_MEM_DstReg == IF_ID_rs) || (IF_ID_UsesRt && (EX_MEM_DstReg == IF_ID_rt)));

    assign load_use   = ID_EX_MemRead && ID_EX_RegWrite && match_e;
    assign br_alu_dep = Branch_ID && ID_EX_RegWrite && match_e && !ID_EX_MemRead;
    assign br_mem_dep = Branch_ID && EX_MEM_MemRead && match_m;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            state   <= state_next;
            mul_cnt <= mul_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        mul_cnt_next = mul_cnt;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        case (state)
            RUN: begin
                if (ID_EX_MulStart) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    // A two-cycle multiply needs only this one stall cycle.
                    if (MUL_LATENCY > 2) begin
                        state_next   = MUL_WAIT;
                        mul_cnt_next = MUL_LOAD;
                    end
                end else if (load_use) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    if (Branch_ID)
                        state_next = BR_LOAD_WAIT;
                end else if (br_alu_dep || br_mem_dep) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end else if (Branch_ID && BranchTaken_ID) begin
                    IF_ID_Flush = 1'b1;
                end
            end
            BR_LOAD_WAIT: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                state_next   = RUN;
            end
            MUL_WAIT: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                // mul_cnt counts the MUL_WAIT cycles still to go, including this one.
                if (mul_cnt <= MW'(1)) begin
                    state_next   = RUN;
                    mul_cnt_next = '0;
                end else begin
                    mul_cnt_next = mul_cnt - MW'(1);
                end
            end
            default: state_next = RUN;
        endcase
        if (Reset) begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
            ID_EX_Bubble = 1'b0;
            IF_ID_Flush  = 1'b0;
        end
    end

    assign Stalled = ~PCWrite;

    always_ff @(posedge Clk) begin
        if (Reset)
            StallCount <= '0;
        else if (!PCWrite && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed bench for hazard_stall_unit.
module tb_hazard_stall_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  IF_ID_rs, IF_ID_rt;
    logic        IF_ID_UsesRt, Branch_ID, BranchTaken_ID;
    logic [4:0]  ID_EX_DstReg;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MulStart;
    logic [4:0]  EX_MEM_DstReg;
    logic        EX_MEM_MemRead;
    logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalled;
    logic [15:0] StallCount;

    int passed = 0;
    int total  = 0;

    localparam logic [4:0] PASS   = 5'b11000;
    localparam logic [4:0] STALLB = 5'b00101;
    localparam logic [4:0] STALLM = 5'b00001;
    localparam logic [4:0] FLUSH  = 5'b11010;

    hazard_stall_unit #(.MUL_LATENCY(4), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_UsesRt(IF_ID_UsesRt),
        .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
        .ID_EX_DstReg(ID_EX_DstReg), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MulStart(ID_EX_MulStart),
        .EX_MEM_DstReg(EX_MEM_DstReg), .EX_MEM_MemRead(EX_MEM_MemRead),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .Stalled(Stalled), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [4:0] exp_ctl, input logic [15:0] exp_cnt);
        logic [4:0] obs_ctl;
        #1;
        obs_ctl = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalled};
        total++;
        assert (obs_ctl === exp_ctl) passed++;
        else $error("FAIL %s ctl observed=%b expected=%b", tag, obs_ctl, exp_ctl);
        total++;
        assert (StallCount === exp_cnt) passed++;
        else $error("FAIL %s count observed=%0d expected=%0d", tag, StallCount, exp_cnt);
    endtask

    task automatic idle();
        IF_ID_rs = 5'd1; IF_ID_rt = 5'd2; IF_ID_UsesRt = 1'b0;
        Branch_ID = 1'b0; BranchTaken_ID = 1'b0;
        ID_EX_DstReg = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_MulStart = 1'b0;
        EX_MEM_DstReg = 5'd0; EX_MEM_MemRead = 1'b0;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic lw_t0();
        ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_DstReg = 5'd8; IF_ID_rs = 5'd8;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        lw_t0();
        chk("reset_outputs", PASS, 16'hxxxx === 16'hxxxx ? StallCount : 16'd0);
        cyc();
        Reset = 1'b0; idle();
        chk("after_reset", PASS, 16'd0);

        cyc(); lw_t0();
        chk("load_use", STALLB, 16'd0);
        cyc(); idle();
        chk("load_use_release", PASS, 16'd1);

        cyc(); lw_t0(); Branch_ID = 1'b1; BranchTaken_ID = 1'b1;
        chk("br_load_1", STALLB, 16'd1);
        cyc(); idle(); Branch_ID = 1'b1; BranchTaken_ID = 1'b1; IF_ID_rs = 5'd8;
        chk("br_load_2", STALLB, 16'd2);
        cyc();
        chk("br_load_flush", FLUSH, 16'd3);
        cyc(); idle();
        chk("flush_one_cycle", PASS, 16'd3);

        cyc(); ID_EX_MulStart = 1'b1;
        chk("mul_1", STALLM, 16'd3);
        cyc(); idle();
        chk("mul_2", STALLM, 16'd4);
        cyc();
        chk("mul_3", STALLM, 16'd5);
        cyc();
        chk("mul_done", PASS, 16'd6);

        cyc(); ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_DstReg = 5'd0; IF_ID_rs = 5'd0;
        chk("reg0_no_dep", PASS, 16'd6);
        cyc(); idle(); ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_DstReg = 5'd9;
        IF_ID_rs = 5'd3; IF_ID_rt = 5'd9; IF_ID_UsesRt = 1'b0;
        chk("rt_unused", PASS, 16'd6);
        cyc(); IF_ID_UsesRt = 1'b1;
        chk("rt_used", STALLB, 16'd6);
        cyc(); idle(); Branch_ID = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_DstReg = 5'd5; IF_ID_rs = 5'd5;
        chk("br_alu_dep", STALLB, 16'd7);
        cyc(); idle(); EX_MEM_MemRead = 1'b1; EX_MEM_DstReg = 5'd6; IF_ID_rs = 5'd6;
        chk("mem_load_no_branch", PASS, 16'd8);
        cyc(); Branch_ID = 1'b1; BranchTaken_ID = 1'b1;
        chk("br_mem_dep", STALLB, 16'd8);
        cyc(); idle(); Branch_ID = 1'b1; BranchTaken_ID = 1'b1;
        chk("taken_flush", FLUSH, 16'd9);

        cyc(); idle(); ID_EX_MulStart = 1'b1;
        chk("mul_rst_1", STALLM, 16'd9);
        cyc(); idle();
        chk("mul_rst_2", STALLM, 16'd10);
        cyc(); Reset = 1'b1;
        chk("mul_rst_pulse", PASS, 16'd11);
        cyc(); Reset = 1'b0;
        chk("mul_rst_run", PASS, 16'd0);

        cyc(); lw_t0();
        for (int i = 0; i < 65541; i++) @(posedge Clk);
        #1;
        chk("saturate", STALLB, 16'hFFFF);
        cyc();
        chk("saturate_hold", STALLB, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
